tb_adc_stim_gen: RTL
====================

# tb_adc_stim_gen

Synthesizable multi-channel ADC stimulus generator that sits directly upstream of the testbench `adc_driver`. It produces per-channel signed sawtooth sample streams and a periodic external-trigger pulse, both on `clk0`. The sawtooths drive `adc_data_in0..3`; the trigger drives `trig_ext` / GPIO bit 0. It replaces ad-hoc stimulus counters with a run-time configurable, self-checking-friendly source.

## Interface
- `DW`, 14: sample width, signed two's complement.
- `NUM_CH`, 4: number of channels, 1..4.
- `TRIG_PER`, 25000: trigger period in `clk0` cycles minus 1; a pulse starts every `TRIG_PER+1` cycles.
- `TRIG_LEN`, 1: trigger pulse width in cycles, 1..`TRIG_PER`.
- `TRIG_ACT_LVL`, 0: active level of `trig_o`.

Ports:
- `clk0`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low; clock `clk0`.
- `en_i`  in  1  run enable. While low, all state holds.
- `cfg_we_i`  in  1  config write strobe, one cycle.
- `cfg_addr_i`  in  4  {ch[3:2], reg[1:0]}. reg: 0 = lo, 1 = hi, 2 = start, 3 = step.
- `cfg_wdata_i`  in  DW  signed config value.
- `ch_dat_o`  out  NUM_CH×DW  per-channel sample.
- `ch_vld_o`  out  1  high in cycles where samples advanced.
- `wrap_o`  out  NUM_CH  one-cycle pulse per channel on wrap.
- `trig_o`  out  1  trigger pulse, active level `TRIG_ACT_LVL`.
- `trig_cnt_o`  out  16  issued trigger count, wraps modulo 2^16.

## Operation
- Reset defaults:
  - lo = −1000, hi = +1000, step = +1 for all channels.
  - start = {−1000, −500, +1000, +500} for ch0..3.
  - `ch_dat_o` = start, `ch_vld_o` = 0, `wrap_o` = 0.
  - `trig_o` = ~`TRIG_ACT_LVL`, `trig_cnt_o` = 0, period counter = 0.
- Per channel, each enabled cycle:
  - If cur ≥ hi: next = lo and `wrap_o[ch]` = 1.
  - Otherwise: next = cur + step, computed in DW+1 bits and clamped to hi when sum > hi. That channel wraps on the following cycle.
  - Negative step is legal; no lower clamp is applied. Underflow below −2^(DW−1) saturates at −2^(DW−1).
  - lo ≥ hi: output settles at lo, and `wrap_o` pulses every cycle once cur ≥ hi.
- Enable edges:
  - `en_i` rising edge (registered compare): all channels reload start, the period counter clears to 0, and `trig_cnt_o` holds.
  - `en_i` low: samples, period counter and `trig_o` hold their values. A pulse in progress is frozen, not truncated.
- Config writes:
  - Accepted regardless of `en_i`.
  - Channel index ≥ NUM_CH: write ignored.
  - lo/hi/step take effect on the next enabled cycle.
  - start takes effect only at the next reload (reset or `en_i` rise).
- Trigger:
  - The period counter counts 0..`TRIG_PER` then wraps to 0.
  - On the wrap cycle, `trig_o` goes active for `TRIG_LEN` cycles and `trig_cnt_o` increments.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Sample latency: `en_i` high at edge N → new sample and `ch_vld_o` = 1 visible after edge N.
- `cfg_we_i` at edge N: the new value is used in the computation at edge N+1, so it is visible in output after N+1.
- Simultaneous cfg write and wrap in the same cycle: the old lo/hi/step are used for that cycle.
- Simultaneous `en_i` rise and cfg write to start: the old start is loaded.
- `trig_o` asserts in the same cycle the period counter wraps and deasserts after exactly `TRIG_LEN` enabled cycles.
- Reset mid-pulse or mid-ramp: the next edge with `rstn` = 0 forces all reset values, including config registers.

## Configuration
- Macro `STIM_WRAP_TRIG_EN`.
- Defined: the trigger source is a channel-0 wrap instead of the period counter. The pulse starts in the cycle after `wrap_o[0]` and lasts `TRIG_LEN` cycles. A re-wrap during an active pulse is ignored. The period counter is not instantiated, and `TRIG_PER` is unused.
- Undefined: the periodic counter trigger described above.

## Test plan
- Reset release, `en_i` = 1, default config:
  - ch0 sequence is −1000, −999, …, +1000, −1000.
  - First `wrap_o[0]` occurs 2001 cycles after the first valid sample.
  - ch1 starts at −500 and, after reaching +1000, wraps to −1000.
- Trigger with `TRIG_PER` = 9, `TRIG_LEN` = 2:
  - `trig_o` is active in cycles 10–11, 20–21, ….
  - `trig_cnt_o` reaches 3 after 30 enabled cycles.
  - Drop `en_i` in cycle 10: `trig_o` stays active and the period counter holds.
- Write step = 7, hi = 20 to ch2 while ch2 = 10:
  - Outputs 10, 17, 20 (clamped), then lo, with `wrap_o[2]` = 1.
- Write start = 100 to ch3 with `en_i` high: no change. Toggle `en_i` 0→1: ch3 = 100 on the first enabled cycle, and the period counter restarts at 0.
- Write lo = 50, hi = 50: the output locks at 50 and `wrap_o` pulses every cycle. Write with ch index 3 when NUM_CH = 2: no state change.
- `STIM_WRAP_TRIG_EN` defined, default config: the `trig_o` pulse follows each `wrap_o[0]` by 1 cycle, with a period of 2001 cycles.

Source files
------------

// File: rtl/tb_adc_stim_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_stim_gen_if
// Brief    : Config bus and sample-stream bundle for the ADC stimulus generator.
// Revision : 1.0 - initial release
// ============================================================================
interface tb_adc_stim_gen_if #(
  parameter int DW     = 14,
  parameter int NUM_CH = 4
);
  logic                 cfg_we_i;
  logic [3:0]           cfg_addr_i;
  logic signed [DW-1:0] cfg_wdata_i;
  logic [NUM_CH*DW-1:0] ch_dat_o;
  logic                 ch_vld_o;
  logic [NUM_CH-1:0]    wrap_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  ch_dat_o, ch_vld_o, wrap_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output ch_dat_o, ch_vld_o, wrap_o
  );
endinterface
`default_nettype wire

// File: rtl/tb_adc_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_stim_gen
// Brief    : Per-channel signed sawtooth generator plus trigger pulse source.
//            Define STIM_WRAP_TRIG_EN to trigger on channel-0 wrap instead of
//            the free-running period counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_stim_gen #(
  parameter int DW           = 14,
  parameter int NUM_CH       = 4,
  parameter int TRIG_PER     = 25000,
  parameter int TRIG_LEN     = 1,
  parameter bit TRIG_ACT_LVL = 1'b0
) (
  input  wire                 clk0,
  input  wire                 rstn,
  input  wire                 en_i,
  tb_adc_stim_gen_if.slave    bus_if,
  output logic                trig_o,
  output logic [15:0]         trig_cnt_o
);

  localparam logic signed [DW:0]   C_SMIN_X = (DW+1)'(-(2 ** (DW-1)));
  localparam logic signed [DW-1:0] C_SMIN   = C_SMIN_X[DW-1:0];
  localparam int                   C_RW     = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;

  function automatic logic signed [DW-1:0] start_rst(input int ch);
    case (ch)
      0:       return DW'(-1000);
      1:       return DW'(-500);
      2:       return DW'(1000);
      default: return DW'(500);
    endcase
  endfunction

  logic                 en_q;
  logic                 vld_q;
  logic                 rise;
  logic [NUM_CH*DW-1:0] dat_w;
  logic [NUM_CH-1:0]    wrap_w;

  assign rise = en_i & ~en_q;

  always_ff @(posedge clk0) begin
    if (!rstn) begin
      en_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      en_q  <= en_i;
      vld_q <= en_i;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [DW-1:0] lo_q, lo_d, hi_q, hi_d, step_q, step_d;
    logic signed [DW-1:0] start_q, start_d, cur_q, cur_d;
    logic                 wrap_q, wrap_d;
    logic signed [DW:0]   cur_x, step_x, hi_x, sum;
    logic                 sel;

    assign sel    = bus_if.cfg_we_i && (bus_if.cfg_addr_i[3:2] == 2'(g));
    assign cur_x  = cur_q;
    assign step_x = step_q;
    assign hi_x   = hi_q;
    assign sum    = cur_x + step_x;

    // Config registers update on the same edge the ramp uses the old values.
    always_comb begin
      lo_d    = lo_q;
      hi_d    = hi_q;
      step_d  = step_q;
      start_d = start_q;
      cur_d   = cur_q;
      wrap_d  = 1'b0;
      if (sel) begin
        case (bus_if.cfg_addr_i[1:0])
          2'd0:    lo_d    = bus_if.cfg_wdata_i;
          2'd1:    hi_d    = bus_if.cfg_wdata_i;
          2'd2:    start_d = bus_if.cfg_wdata_i;
          default: step_d  = bus_if.cfg_wdata_i;
        endcase
      end
      if (en_i) begin
        if (rise) begin
          cur_d = start_q;
        end else if (cur_q >= hi_q) begin
          cur_d  = lo_q;
          wrap_d = 1'b1;
        end else if (sum > hi_x) begin
          cur_d = hi_q;
        end else if (sum < C_SMIN_X) begin
          cur_d = C_SMIN;
        end else begin
          cur_d = sum[DW-1:0];
        end
      end
    end

    always_ff @(posedge clk0) begin
      if (!rstn) begin
        lo_q    <= DW'(-1000);
        hi_q    <= DW'(1000);
        step_q  <= DW'(1);
        start_q <= start_rst(g);
        cur_q   <= start_rst(g);
        wrap_q  <= 1'b0;
      end else begin
        lo_q    <= lo_d;
        hi_q    <= hi_d;
        step_q  <= step_d;
        start_q <= start_d;
        cur_q   <= cur_d;
        wrap_q  <= wrap_d;
      end
    end

    assign dat_w[g*DW +: DW] = cur_q;
    assign wrap_w[g]         = wrap_q;
  end

  assign bus_if.ch_dat_o = dat_w;
  assign bus_if.ch_vld_o = vld_q;
  assign bus_if.wrap_o   = wrap_w;

  logic             trig_start;
  logic             act_q, act_d;
  logic [C_RW-1:0]  rem_q, rem_d;
  logic [15:0]      tcnt_q, tcnt_d;

`ifdef STIM_WRAP_TRIG_EN
  assign trig_start = en_i & wrap_w[0] & ~act_q;
`else
  localparam int C_CW = (TRIG_PER > 0) ? $clog2(TRIG_PER + 1) : 1;
  logic [C_CW-1:0] per_q, per_d;

  always_comb begin
    per_d = per_q;
    if (en_i) begin
      if (rise || (per_q == C_CW'(TRIG_PER))) per_d = '0;
      else                                    per_d = per_q + 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstn) per_q <= '0;
    else       per_q <= per_d;
  end

  assign trig_start = en_i & ~rise & (per_q == C_CW'(TRIG_PER));
`endif

  // Pulse only ages on enabled cycles, so dropping en_i freezes it mid-pulse.
  always_comb begin
    act_d  = act_q;
    rem_d  = rem_q;
    tcnt_d = tcnt_q;
    if (trig_start) begin
      act_d  = 1'b1;
      rem_d  = C_RW'(TRIG_LEN - 1);
      tcnt_d = tcnt_q + 16'd1;
    end else if (en_i && act_q) begin
      if (rem_q == '0) act_d = 1'b0;
      else             rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstn) begin
      act_q  <= 1'b0;
      rem_q  <= '0;
      tcnt_q <= '0;
    end else begin
      act_q  <= act_d;
      rem_q  <= rem_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign trig_o     = act_q ? TRIG_ACT_LVL : ~TRIG_ACT_LVL;
  assign trig_cnt_o = tcnt_q;

endmodule
`default_nettype wire
